// File: rtl/bcd2ascii_ser.sv
// bcd2ascii_ser: buffers sign-magnitude BCD words and streams them as ASCII bytes
module bcd2ascii_ser #(
  parameter int         FIFO_DEPTH = 4,
  parameter bit         TERM_EN    = 1'b1,
  parameter logic [7:0] TERM_CHAR  = 8'h0A
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [16:0]                   bcd_i,
  input  logic                          bcd_vld_i,
  output logic [7:0]                    ch_o,
  output logic                          ch_vld_o,
  input  logic                          ch_rdy_i,
  output logic                          drop_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_lvl_o,
  output logic                          busy_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  typedef enum logic [1:0] {IDLE, SIGN, DIG, TERM} state_t;
  state_t          state_q;
  logic [16:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   wp_q, rp_q;
  logic [LW-1:0]   lvl_q, lvl_d;
  logic [15:0]     dig_q;
  logic [1:0]      idx_q;
  logic [7:0]      ch_q;
  logic            ch_vld_q, drop_q;
  logic            push, pop, acc, last, head_neg;
  logic [16:0]     head;
  logic [1:0]      head_idx;
  logic [3:0]      head_dig, cur_dig, nxt_dig;
  function automatic logic [7:0] asc(input logic [3:0] d);
    return d > 4'd9 ? 8'h3F : 8'h30 + {4'h0, d};
  endfunction
  always_comb begin
    acc      = ch_vld_q & ch_rdy_i;
    last     = state_q == TERM || (state_q == DIG && idx_q == 2'd0 && !TERM_EN);
    push     = bcd_vld_i && lvl_q != LW'(FIFO_DEPTH);
    pop      = lvl_q != '0 && (state_q == IDLE || (acc && last));
    lvl_d    = lvl_q + LW'(push) - LW'(pop);
    head     = mem[rp_q];
    head_idx = head[15:12] != 4'd0 ? 2'd3 : head[11:8] != 4'd0 ? 2'd2 : head[7:4] != 4'd0 ? 2'd1 : 2'd0;
    head_neg = head[16] && head[15:0] != 16'd0;
    head_dig = head[{head_idx, 2'b00} +: 4];
    cur_dig  = dig_q[{idx_q, 2'b00} +: 4];
    nxt_dig  = dig_q[{idx_q - 2'd1, 2'b00} +: 4];
  end
  always_ff @(posedge clk) begin
    if (push) mem[wp_q] <= bcd_i;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wp_q   <= '0;
      rp_q   <= '0;
      lvl_q  <= '0;
      drop_q <= 1'b0;
    end else begin
      wp_q   <= push ? wp_q + 1'b1 : wp_q;
      rp_q   <= pop ? rp_q + 1'b1 : rp_q;
      lvl_q  <= lvl_d;
      drop_q <= bcd_vld_i && !push;
    end
  end
  // A pop always loads the next word, covering both IDLE and the last-character handoff
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      dig_q    <= '0;
      idx_q    <= '0;
      ch_q     <= '0;
      ch_vld_q <= 1'b0;
    end else if (pop) begin
      dig_q    <= head[15:0];
      idx_q    <= head_idx;
      state_q  <= head_neg ? SIGN : DIG;
      ch_q     <= head_neg ? 8'h2D : asc(head_dig);
      ch_vld_q <= 1'b1;
    end else if (acc) begin
      if (state_q == SIGN) begin
        state_q <= DIG;
        ch_q    <= asc(cur_dig);
      end else if (state_q == DIG && idx_q != 2'd0) begin
        idx_q <= idx_q - 2'd1;
        ch_q  <= asc(nxt_dig);
      end else if (state_q == DIG && TERM_EN) begin
        state_q <= TERM;
        ch_q    <= TERM_CHAR;
      end else begin
        state_q  <= IDLE;
        ch_q     <= '0;
        ch_vld_q <= 1'b0;
      end
    end
  end
  assign ch_o       = ch_q;
  assign ch_vld_o   = ch_vld_q;
  assign drop_o     = drop_q;
  assign fifo_lvl_o = lvl_q;
  assign busy_o     = lvl_q != '0 || state_q != IDLE;
endmodule

// File: tb/tb_bcd2ascii_ser.sv
// tb_bcd2ascii_ser: per-cycle check of bcd2ascii_ser against a queue-of-strings model
module tb_bcd2ascii_ser;
  localparam int         DEPTH = 4;
  localparam logic [7:0] TERM  = 8'h0A;
  logic        clk, rstn, bcd_vld_i, ch_vld_o, ch_rdy_i, drop_o, busy_o;
  logic [16:0] bcd_i;
  logic [7:0]  ch_o;
  logic [2:0]  fifo_lvl_o;
  int          checks = 0, errors = 0, ndrop = 0, maxlvl = 0;
  logic        rmode, rval;
  logic [16:0] fq[$];
  logic [7:0]  cur[$], got[$];
  logic        drop_e;

  bcd2ascii_ser dut (
    .clk(clk), .rstn(rstn), .bcd_i(bcd_i), .bcd_vld_i(bcd_vld_i),
    .ch_o(ch_o), .ch_vld_o(ch_vld_o), .ch_rdy_i(ch_rdy_i), .drop_o(drop_o),
    .fifo_lvl_o(fifo_lvl_o), .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Render a word as the character string it must produce
  function automatic void load(input logic [16:0] w);
    logic [3:0] d[4];
    int first = 3;
    bit found = 0;
    for (int i = 0; i < 4; i++) begin
      d[i] = w[15-4*i -: 4];
      if (!found && d[i] != 4'd0) begin
        first = i;
        found = 1;
      end
    end
    if (w[16] && w[15:0] != 16'd0) cur.push_back(8'h2D);
    for (int i = first; i < 4; i++) cur.push_back(d[i] > 4'd9 ? 8'h3F : 8'h30 + 8'(d[i]));
    cur.push_back(TERM);
  endfunction

  always @(negedge clk) ch_rdy_i = rmode ? 1'($urandom % 2) : rval;

  always begin
    logic s_rst, s_bv, s_rdy, s_dv;
    logic [16:0] s_b;
    logic [7:0] s_ch;
    bit full;
    @(negedge clk);
    #4;
    s_rst = rstn; s_bv = bcd_vld_i; s_b = bcd_i; s_rdy = ch_rdy_i; s_dv = ch_vld_o; s_ch = ch_o;
    @(posedge clk);
    if (!s_rst) begin
      fq.delete();
      cur.delete();
      drop_e = 1'b0;
    end else begin
      full = fq.size() == DEPTH;
      drop_e = s_bv && full;
      if (s_dv && s_rdy) got.push_back(s_ch);
      if (cur.size() > 0 && s_rdy) void'(cur.pop_front());
      if (cur.size() == 0 && fq.size() > 0) load(fq.pop_front());
      if (s_bv && !full) fq.push_back(s_b);
    end
    #1;
    chk("ch_vld", int'(ch_vld_o), int'(cur.size() > 0));
    if (cur.size() > 0) chk("ch", int'(ch_o), int'(cur[0]));
    chk("fifo_lvl", int'(fifo_lvl_o), fq.size());
    chk("busy", int'(busy_o), int'(fq.size() > 0 || cur.size() > 0));
    chk("drop", int'(drop_o), int'(drop_e));
    if (drop_o) ndrop++;
    if (int'(fifo_lvl_o) > maxlvl) maxlvl = int'(fifo_lvl_o);
  end

  task automatic drive(input logic v, input logic [16:0] w);
    @(negedge clk);
    bcd_vld_i = v;
    bcd_i = w;
  endtask

  task automatic drain(input string name);
    bit done = 0;
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge clk);
      done = !busy_o && !ch_vld_o;
    end
    chk({name, "_drain"}, int'(done), 1);
  endtask

  task automatic expect_seq(input string name, input logic [127:0] exp, input int n);
    chk({name, "_len"}, got.size(), n);
    for (int i = 0; i < n && i < got.size(); i++) chk(name, int'(got[i]), int'(exp[8*(n-1-i) +: 8]));
    got.delete();
  endtask

  task automatic send_check(input string name, input logic [16:0] w, input logic [127:0] exp, input int n);
    drive(1'b1, w);
    drive(1'b0, '0);
    drain(name);
    expect_seq(name, exp, n);
  endtask

  function automatic logic [16:0] rnd_word();
    logic [16:0] w;
    w[16] = 1'($urandom % 2);
    for (int i = 0; i < 4; i++) begin
      int r = int'($urandom % 10);
      w[4*i +: 4] = r < 4 ? 4'd0 : r == 9 ? 4'(10 + $urandom % 6) : 4'($urandom % 10);
    end
    return w;
  endfunction

  initial begin
    bit found = 0;
    rstn = 1'b0; bcd_vld_i = 1'b0; bcd_i = '0; rmode = 1'b0; rval = 1'b1;
    #3;
    chk("rst_ch", int'(ch_o), 0);
    chk("rst_ch_vld", int'(ch_vld_o), 0);
    chk("rst_drop", int'(drop_o), 0);
    chk("rst_lvl", int'(fifo_lvl_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    // zero word with explicit two-edge latency
    drive(1'b1, 17'h00000);
    @(posedge clk); #1;
    chk("lat_edge1", int'(ch_vld_o), 0);
    drive(1'b0, '0);
    @(posedge clk); #1;
    chk("lat_edge2_vld", int'(ch_vld_o), 1);
    chk("lat_edge2_ch", int'(ch_o), 8'h30);
    drain("zero");
    expect_seq("zero", 128'h300A, 2);
    send_check("max", 17'h01023, 128'h313032330A, 5);
    send_check("inner0", 17'h00070, 128'h37300A, 3);
    send_check("neg5", 17'h10005, 128'h2D350A, 3);
    send_check("neg1023", 17'h11023, 128'h2D313032330A, 6);
    send_check("negzero", 17'h10000, 128'h300A, 2);
    send_check("badbcd", 17'h000A5, 128'h3F350A, 3);
    // back-to-back words, first with random stalls then with ch_rdy high
    rmode = 1'b1;
    drive(1'b1, 17'h00999);
    drive(1'b1, 17'h10042);
    drive(1'b0, '0);
    drain("bp");
    expect_seq("bp", 128'h3939390A2D34320A, 8);
    rmode = 1'b0;
    drive(1'b1, 17'h00999);
    drive(1'b1, 17'h10042);
    drive(1'b0, '0);
    drain("nobubble");
    expect_seq("nobubble", 128'h3939390A2D34320A, 8);
    // overflow with the sink stalled
    rval = 1'b0;
    @(negedge clk);
    ndrop = 0; maxlvl = 0;
    for (int i = 1; i <= 6; i++) drive(1'b1, 17'(i));
    drive(1'b0, '0);
    repeat (3) @(negedge clk);
    chk("ovf_drops", ndrop, 1);
    chk("ovf_maxlvl", maxlvl, 4);
    rval = 1'b1;
    drain("ovf");
    expect_seq("ovf", 128'h310A320A330A340A350A, 10);
    // asynchronous reset while the hundreds digit is presented
    drive(1'b1, 17'h01023);
    drive(1'b0, '0);
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = ch_vld_o && ch_o == 8'h30;
    end
    chk("rst_found", int'(found), 1);
    #2 rstn = 1'b0;
    #1;
    chk("arst_ch_vld", int'(ch_vld_o), 0);
    chk("arst_lvl", int'(fifo_lvl_o), 0);
    chk("arst_busy", int'(busy_o), 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    got.delete();
    repeat (10) @(negedge clk);
    chk("arst_residual", got.size(), 0);
    chk("arst_idle_busy", int'(busy_o), 0);
    // randomized traffic with random backpressure
    rmode = 1'b1;
    for (int i = 0; i < 600; i++) drive($urandom % 3 == 0, rnd_word());
    drive(1'b0, '0);
    drain("random");
    rmode = 1'b0;
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bcd2ascii_ser.md
# bcd2ascii_ser

Downstream consumer of the `bin2bcd` converter. It takes 17-bit sign-magnitude BCD words on a valid strobe that has no backpressure, and buffers them in a small FIFO. It then streams each word out as ASCII characters over a valid/ready byte interface, for a UART TX or log sink. Leading zeros are suppressed, a '-' prefix marks negative values, and an optional terminator character ends each word.

## Interface
- FIFO_DEPTH, 4, word FIFO depth; power of 2, ≥2.
- TERM_EN, 1, 1 = append TERM_CHAR after each word's digits.
- TERM_CHAR, 8'h0A, terminator character.
- clk  in  1  clock; all logic on posedge.
- rstn  in  1  reset; asynchronous, active-low.
- bcd  in  17  [16] sign (1 = negative), [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] units.
- bcd_vld  in  1  word strobe; sampled every posedge; no ready returned.
- ch  out  8  ASCII character.
- ch_vld  out  1  ch valid.
- ch_rdy  in  1  sink accepts ch when ch_vld & ch_rdy at posedge.
- drop  out  1  one-cycle pulse: the incoming word was discarded because the FIFO was full.
- fifo_lvl  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- busy  out  1  high when the FIFO is non-empty or the FSM is not IDLE.

## Operation
- **FIFO write.** On bcd_vld, the word is written if fifo_lvl < FIFO_DEPTH, using the occupancy before the edge. A same-edge pop does not free space for that write; a word arriving while the FIFO is full is dropped and drop pulses.
- **Simultaneous push and pop.** When not full, both happen and fifo_lvl is unchanged.
- **FSM states.** IDLE, SIGN, DIG, TERM.
- **IDLE.** If the FIFO is non-empty, pop one word into the working register.
  - Compute the first significant digit index: the highest nonzero digit, or units if all digits are zero.
  - Go to SIGN if sign=1 and magnitude ≠ 0, otherwise go to DIG.
- **SIGN.** ch = 8'h2D ('-').
- **DIG.** ch = 8'h30 + digit for digits 0–9; a digit >9 emits 8'h3F ('?').
  - Digits go from the first significant digit down to units.
  - After units: go to TERM if TERM_EN, otherwise end the word.
- **TERM.** ch = TERM_CHAR.
- **End of word.** On acceptance of the last character:
  - if the FIFO is non-empty, pop the next word on that same edge and present its first character next cycle (no bubble);
  - otherwise go to IDLE.
- **Negative zero.** A negative-zero word (17'h10000) prints as "0".
- **ch_vld.** High in SIGN, DIG and TERM.
- **Holding.** ch and ch_vld hold stable while ch_vld & !ch_rdy; the state advances only on acceptance.
- **Capacity.** FIFO_DEPTH words in the FIFO plus one in the working register.

## Timing
- **Reset values.** ch=8'h00, ch_vld=0, drop=0, fifo_lvl=0, busy=0, FSM=IDLE, FIFO pointers 0. Reset takes effect immediately, and any word in flight is lost.
- **Latency.** bcd_vld sampled at edge k → pop at edge k+1 → ch_vld=1 with the first character during cycle k+1..k+2.
- **Throughput.** One character per cycle with ch_rdy held high.
  - A word is 1–6 characters: optional sign, 1–4 digits, optional terminator.
  - Sustained input rate must not exceed this character rate; any excess is dropped.
- **drop.** Asserted in the cycle after the rejecting edge, for one cycle.
- **fifo_lvl and busy.** Registered; they reflect post-edge state.
- **ch_rdy while ch_vld=0.** Ignored.

## Test plan
- **Zero.** bcd=17'h00000, TERM_EN=1, ch_rdy=1 → 8'h30, 8'h0A on consecutive cycles; first char two edges after bcd_vld.
- **Maximum positive.** bcd=17'h01023 → 31,30,32,33,0A; bcd=17'h00070 → 37,30,0A (leading zeros suppressed, inner/trailing zeros kept).
- **Negative values.** bcd=17'h10005 → 2D,35,0A; bcd=17'h11023 → 2D,31,30,32,33,0A; bcd=17'h10000 → 30,0A.
- **Backpressure.** Feed words 17'h00999 and 17'h10042 back-to-back, with ch_rdy randomly toggled.
  - Expected: exact sequence 39,39,39,0A,2D,34,32,0A.
  - ch must be stable throughout every stall; no bubble between the words when ch_rdy=1.
- **Overflow.** FIFO_DEPTH=4, ch_rdy=0, six consecutive bcd_vld cycles.
  - Words 1–5 are accepted; word 6 gives drop=1 for one cycle; fifo_lvl reaches 4.
  - Releasing ch_rdy emits exactly words 1–5 in order.
- **Reset mid-word.** Assert rstn=0 while the hundreds digit of 17'h01023 is being output.
  - ch_vld drops to 0 asynchronously; fifo_lvl=0, busy=0.
  - After release, no residual characters until the next bcd_vld.
